// File: rtl/mul_dispatch_pkg.sv
// Shared types and constants for the M-extension dispatch block.
package mul_dispatch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TagW = 5;

  typedef enum logic [2:0] {
    F3Mul    = 3'd0,
    F3Mulh   = 3'd1,
    F3Mulhsu = 3'd2,
    F3Mulhu  = 3'd3,
    F3Div    = 3'd4,
    F3Divu   = 3'd5,
    F3Rem    = 3'd6,
    F3Remu   = 3'd7
  } funct3_e;

  typedef enum logic [1:0] {
    OccEmpty,
    OccPartial,
    OccFull
  } occ_e;

  typedef struct packed {
    funct3_e         para;
    logic [XLEN-1:0] rs0;
    logic [XLEN-1:0] rs1;
    logic [TagW-1:0] rd;
  } mul_req_t;

  function automatic occ_e occ_of(int unsigned count, int unsigned depth);
    if (count == 0) return OccEmpty;
    if (count >= depth) return OccFull;
    return OccPartial;
  endfunction

endpackage

// File: rtl/mul_tag_fifo.sv
// In-order FIFO of destination tags for multiplier/divider operations in flight.
module mul_tag_fifo
  import mul_dispatch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [TagW-1:0] push_tag_i,
  input  logic            pop_i,
  output logic [TagW-1:0] head_tag_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [TagW-1:0] mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (count_q == CntW'(Depth));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_tag_o = mem_q[rd_ptr_q];
  assign do_push    = push_i & ~full_o & ~flush_i;
  assign do_pop     = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      // Simultaneous push and pop leaves the count alone.
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
  end

endmodule

// File: rtl/mul_dispatch.sv
// Dispatches M-extension ops to the multiplier/divider and retires results in order.
// Define MUL_DISPATCH_SKID_EN to register the request path through a one-entry skid.
module mul_dispatch
  import mul_dispatch_pkg::*;
#(
  parameter int unsigned TAG_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_pipeline,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_para,
  input  logic [XLEN-1:0] in_rs0,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [TagW-1:0] in_rd,
  output logic            mul_initial,
  output logic [2:0]      mul_para,
  output logic [XLEN-1:0] mul_rs0,
  output logic [XLEN-1:0] mul_rs1,
  input  logic            mul_ready,
  input  logic            mul_finished,
  input  logic [XLEN-1:0] mul_data,
  output logic            mul_ack,
  output logic            wb_valid,
  output logic [TagW-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            wb_ready,
  output logic [XLEN-1:0] pend_mask
);

  localparam int unsigned CntW = $clog2(TAG_DEPTH + 1);

  mul_req_t        in_req, mul_req;
  logic            issue, stall, waw;
  logic            fifo_full, fifo_empty;
  logic [TagW-1:0] head_tag;
  logic [CntW-1:0] fifo_count;
  logic [XLEN-1:0] pend_mask_q, pend_mask_d;
  occ_e            occ;
  logic            proto_err;

  assign in_req = '{para: funct3_e'(in_para), rs0: in_rs0, rs1: in_rs1, rd: in_rd};

`ifdef MUL_DISPATCH_SKID_EN
  logic     skid_valid_q, skid_valid_d;
  mul_req_t skid_q, skid_d;

  assign mul_req     = skid_q;
  // rd=0 never conflicts, so it is excluded from the skid match.
  assign waw         = pend_mask_q[in_rd] |
                       (skid_valid_q & (skid_q.rd == in_rd) & (in_rd != '0));
  assign stall       = fifo_full | waw | clear_pipeline;
  assign mul_initial = ~rst & skid_valid_q & ~fifo_full & ~clear_pipeline;
  assign in_ready    = ~rst & ~stall & (~skid_valid_q | issue);

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (clear_pipeline) begin
      skid_valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      skid_valid_d = 1'b1;
      skid_d       = in_req;
    end else if (issue) begin
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end
`else
  assign mul_req     = in_req;
  assign waw         = pend_mask_q[in_rd];
  assign stall       = fifo_full | waw | clear_pipeline;
  assign in_ready    = ~rst & ~stall & mul_ready;
  assign mul_initial = in_valid & in_ready;
`endif

  assign issue    = mul_initial & mul_ready & ~clear_pipeline;
  assign mul_para = mul_req.para;
  assign mul_rs0  = mul_req.rs0;
  assign mul_rs1  = mul_req.rs1;

  assign wb_valid  = ~rst & mul_finished & ~fifo_empty & ~clear_pipeline;
  assign wb_rd     = head_tag;
  assign wb_data   = mul_data;
  assign mul_ack   = wb_valid & wb_ready;
  assign pend_mask = pend_mask_q;

  always_comb begin
    pend_mask_d = pend_mask_q;
    if (clear_pipeline) begin
      pend_mask_d = '0;
    end else begin
      if (mul_ack) pend_mask_d[head_tag] = 1'b0;
      if (issue)   pend_mask_d[mul_req.rd] = 1'b1;
    end
    pend_mask_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_mask_q <= '0;
    end else begin
      pend_mask_q <= pend_mask_d;
    end
  end

  mul_tag_fifo #(
    .Depth (TAG_DEPTH),
    .CntW  (CntW)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (clear_pipeline),
    .push_i     (issue),
    .push_tag_i (mul_req.rd),
    .pop_i      (mul_ack),
    .head_tag_o (head_tag),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // A result with nothing outstanding means the multiplier and the tag FIFO disagree.
  assign occ       = occ_of(32'(fifo_count), TAG_DEPTH);
  assign proto_err = ~rst & ~clear_pipeline & mul_finished & (occ == OccEmpty);

  assert property (@(posedge clk) !proto_err);

endmodule

// File: tb/tb_mul_dispatch.sv
// Randomized scoreboard bench for mul_dispatch with a behavioural multiplier/divider model.
module tb_mul_dispatch;
  import mul_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clear_pipeline;
  logic        in_valid, in_ready;
  logic [2:0]  in_para;
  logic [31:0] in_rs0, in_rs1;
  logic [4:0]  in_rd;
  logic        mul_initial, mul_ready, mul_finished, mul_ack;
  logic [2:0]  mul_para;
  logic [31:0] mul_rs0, mul_rs1, mul_data;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, pend_mask;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rand_phase = 0;
  int force_lat = 0;

  typedef struct { logic [4:0] rd; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] res; int done; } op_t;
  exp_t exp_q[$];
  op_t  mq[$];
  logic [4:0]  ack_rd_q[$];
  int          ack_cyc_q[$];
  logic [4:0]  last_wb_rd;
  logic [31:0] last_wb_data;
  int          wb_count = 0;

  mul_dispatch #(.TAG_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear_pipeline (clear_pipeline),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_para        (in_para),
    .in_rs0         (in_rs0),
    .in_rs1         (in_rs1),
    .in_rd          (in_rd),
    .mul_initial    (mul_initial),
    .mul_para       (mul_para),
    .mul_rs0        (mul_rs0),
    .mul_rs1        (mul_rs1),
    .mul_ready      (mul_ready),
    .mul_finished   (mul_finished),
    .mul_data       (mul_data),
    .mul_ack        (mul_ack),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_ready       (wb_ready),
    .pend_mask      (pend_mask)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_calc(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier/divider model: in-order pipeline, up to 4 ops, per-op latency.
  initial begin
    logic       s_issue, s_ack, s_clr;
    logic [2:0] s_para;
    logic [31:0] s_a, s_b;
    int lat;
    mul_ready = 1'b1;
    mul_finished = 1'b0;
    mul_data = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      s_issue = mul_initial & mul_ready & ~clear_pipeline;
      s_ack   = mul_ack;
      s_clr   = clear_pipeline | rst;
      s_para  = mul_para;
      s_a     = mul_rs0;
      s_b     = mul_rs1;
      @(posedge clk);
      #1;
      if (s_clr) begin
        mq.delete();
      end else begin
        if (s_ack && mq.size() > 0) void'(mq.pop_front());
        if (s_issue) begin
          lat = (force_lat != 0) ? force_lat : (rand_phase ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 4)));
          mq.push_back('{res: ref_calc(s_para, s_a, s_b), done: cyc + lat});
        end
      end
      mul_finished = (mq.size() > 0) && (cyc >= mq[0].done);
      mul_data     = mul_finished ? mq[0].res : 32'hDEAD_BEEF;
      mul_ready    = (mq.size() < 4) && (!rand_phase || ($urandom_range(0, 3) != 0));
    end
  end

  // Scoreboard: push on accept, pop and compare on each writeback handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (clear_pipeline) chk("wb_gated_by_clear", 32'(wb_valid), 32'd0);
        if (wb_valid && wb_ready) begin
          chk("mul_ack_on_wb", 32'(mul_ack), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wb_unexpected actual=rd%0d/%h required=no_writeback", wb_rd, wb_data);
          end else begin
            e = exp_q.pop_front();
            chk("wb_rd", 32'(wb_rd), 32'(e.rd));
            chk("wb_data", wb_data, e.data);
          end
          last_wb_rd   = wb_rd;
          last_wb_data = wb_data;
          wb_count++;
          ack_rd_q.push_back(wb_rd);
          ack_cyc_q.push_back(cyc);
        end
        if (in_valid && in_ready)
          exp_q.push_back('{rd: in_rd, data: ref_calc(in_para, in_rs0, in_rs1)});
        if (clear_pipeline) exp_q.delete();
      end
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_phase) begin
      wb_ready       = ($urandom_range(0, 3) != 0);
      clear_pipeline = ($urandom_range(0, 39) == 0);
    end
  endtask

  task automatic send(input logic [2:0] p, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    bit acc = 0;
    in_valid = 1'b1;
    in_para  = p;
    in_rs0   = a;
    in_rs1   = b;
    in_rd    = rd;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      step();
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && mq.size() == 0) done = 1;
      step();
    end
    chk("drain", 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] sp [5];
    sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    bit got;
    int n0, ack_c, acc_c;
    rst = 1'b1; clear_pipeline = 1'b0; wb_ready = 1'b1;
    in_valid = 1'b1; in_para = 3'd0; in_rs0 = 32'd1; in_rs1 = 32'd1; in_rd = 5'd1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mul_initial", 32'(mul_initial), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_mul_ack", 32'(mul_ack), 32'd0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_pend", pend_mask, 32'd0);
    chk("post_rst_empty", 32'(dut.fifo_empty), 32'd1);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // MUL 7*6 -> rd5, pending bit tracks the op.
    force_lat = 5;
    send(3'd0, 32'd7, 32'd6, 5'd5);
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (pend_mask[5]) got = 1;
      step();
    end
    chk("pend5_set", 32'(got), 32'd1);
    wait_idle(50);
    @(negedge clk);
    chk("pend5_cleared", pend_mask, 32'd0);
    chk("mul_rd", 32'(last_wb_rd), 32'd5);
    chk("mul_data", last_wb_data, 32'd42);
    step();
    force_lat = 0;

    send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    wait_idle(50);
    chk("mulhu_data", last_wb_data, 32'hFFFF_FFFE);
    send(3'd4, 32'd100, 32'd0, 5'd10);
    wait_idle(50);
    chk("div0_data", last_wb_data, 32'hFFFF_FFFF);
    send(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11);
    wait_idle(50);
    chk("rem_neg_data", last_wb_data, 32'hFFFF_FFFF);

    // rd=0 writes back but never marks pending.
    force_lat = 4;
    send(3'd0, 32'd5, 32'd5, 5'd0);
    step();
    @(negedge clk);
    chk("rd0_no_pend", pend_mask, 32'd0);
    step();
    wait_idle(50);
    chk("rd0_wb_rd", 32'(last_wb_rd), 32'd0);
    chk("rd0_wb_data", last_wb_data, 32'd25);
    force_lat = 0;

    // Back-to-back with writeback blocked fills the FIFO; retire order and timing.
    wb_ready = 1'b0;
    send(3'd0, 32'd3, 32'd3, 5'd3);
    send(3'd0, 32'd4, 32'd4, 5'd4);
    step();
    in_valid = 1'b1; in_para = 3'd0; in_rs0 = 32'd1; in_rs1 = 32'd1; in_rd = 5'd10;
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("fifo_full", 32'(dut.fifo_full), 32'd1);
    step();
    in_valid = 1'b0;
    repeat (17) step();
    n0 = ack_rd_q.size();
    wb_ready = 1'b1;
    wait_idle(50);
    chk("full_ack_count", 32'(ack_rd_q.size() - n0), 32'd2);
    if (ack_rd_q.size() >= n0 + 2) begin
      chk("full_first_rd", 32'(ack_rd_q[n0]), 32'd3);
      chk("full_second_rd", 32'(ack_rd_q[n0+1]), 32'd4);
      chk("full_consecutive", 32'(ack_cyc_q[n0+1] - ack_cyc_q[n0]), 32'd1);
    end

    // Flush of a long DIVU in flight, then a fresh op.
    force_lat = 10;
    send(3'd5, 32'hFFFF_FFFF, 32'd3, 5'd12);
    step();
    @(negedge clk);
    chk("flush_pend_before", 32'(pend_mask[12]), 32'd1);
    step();
    n0 = wb_count;
    clear_pipeline = 1'b1;
    @(negedge clk);
    chk("flush_mul_initial", 32'(mul_initial), 32'd0);
    step();
    clear_pipeline = 1'b0;
    @(negedge clk);
    chk("flush_pend", pend_mask, 32'd0);
    chk("flush_empty", 32'(dut.fifo_empty), 32'd1);
    repeat (15) step();
    chk("flush_no_wb", 32'(wb_count - n0), 32'd0);
    force_lat = 0;
    send(3'd0, 32'd2, 32'd3, 5'd13);
    wait_idle(50);
    chk("post_flush_data", last_wb_data, 32'd6);
    chk("post_flush_rd", 32'(last_wb_rd), 32'd13);

    // Clear while a finished result is presented kills wb_valid and mul_ack that cycle.
    force_lat = 1;
    wb_ready = 1'b0;
    send(3'd0, 32'd9, 32'd9, 5'd14);
    repeat (4) step();
    @(negedge clk);
    chk("held_wb_valid", 32'(wb_valid), 32'd1);
    step();
    clear_pipeline = 1'b1;
    wb_ready = 1'b1;
    @(negedge clk);
    chk("clear_wb_valid", 32'(wb_valid), 32'd0);
    chk("clear_mul_ack", 32'(mul_ack), 32'd0);
    step();
    clear_pipeline = 1'b0;
    @(negedge clk);
    chk("clear_pend", pend_mask, 32'd0);
    step();
    force_lat = 0;

    // WAW: second rd8 must wait until the first rd8 has been acknowledged.
    force_lat = 6;
    send(3'd0, 32'd8, 32'd8, 5'd8);
    in_valid = 1'b1; in_para = 3'd0; in_rs0 = 32'd2; in_rs1 = 32'd8; in_rd = 5'd8;
    ack_c = -1; acc_c = -1;
    for (int i = 0; i < 60 && acc_c < 0; i++) begin
      @(negedge clk);
      if (mul_ack && wb_rd == 5'd8) ack_c = cyc;
      if (in_ready) acc_c = cyc;
      step();
    end
    in_valid = 1'b0;
    chk("waw_ack_seen", 32'(ack_c >= 0), 32'd1);
    chk("waw_accept_after_ack", 32'(acc_c > ack_c), 32'd1);
    wait_idle(50);
    chk("waw_second_data", last_wb_data, 32'd16);
    force_lat = 0;

    // Randomized traffic with random backpressure and occasional flushes.
    rand_phase = 1;
    for (int n = 0; n < 300; n++) begin
      send(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 5'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 2)) step();
    end
    rand_phase = 0;
    clear_pipeline = 1'b0;
    wb_ready = 1'b1;
    wait_idle(500);
    @(negedge clk);
    chk("final_pend", pend_mask, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
